// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit multiplexed display controller: a serial double-dabble converter
// feeds display registers, which a free-running scan engine drives to the digits.
module seven_seg_scan_ctrl #(
  parameter int unsigned CLK_DIV  = 50000,
  parameter bit          LZ_BLANK = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [13:0] value_in,
  input  logic        load,
  output logic        busy,
  output logic        overflow,
  output logic [3:0]  digit_bcd,
  output logic [3:0]  digit_sel
);

  localparam int unsigned VW = 14;
  localparam int unsigned BW = 16;
  localparam int unsigned PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);
  localparam logic [VW-1:0] VAL_MAX = VW'(9999);

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t        state;
  logic [VW-1:0] opnd;
  logic [BW-1:0] bcd;
  logic [BW-1:0] bcd_adj;
  logic [BW-1:0] bcd_step;
  logic [3:0]    bit_cnt;
  logic          ovf_pend;
  logic [BW-1:0] disp;
  logic [PW-1:0] pre;
  logic [1:0]    idx;
  logic [3:0]    blank;

  // One double-dabble step: add 3 to every nibble >= 5, then shift in the next operand bit.
  always_comb begin
    bcd_adj = bcd;
    for (int k = 0; k < 4; k++) begin
      if (bcd[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
    end
    bcd_step = {bcd_adj[BW-2:0], opnd[VW-1]};
  end

  // Capture/convert controller; display registers are only written on the final step.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      overflow <= 1'b0;
      opnd     <= '0;
      bcd      <= '0;
      bit_cnt  <= '0;
      ovf_pend <= 1'b0;
      disp     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            opnd     <= (value_in > VAL_MAX) ? VAL_MAX : value_in;
            ovf_pend <= (value_in > VAL_MAX);
            bcd      <= '0;
            bit_cnt  <= '0;
            busy     <= 1'b1;
            state    <= CONVERT;
          end
        end
        CONVERT: begin
          bcd     <= bcd_step;
          opnd    <= {opnd[VW-2:0], 1'b0};
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd13) begin
            disp     <= bcd_step;
            overflow <= ovf_pend;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A digit is blank when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    blank    = 4'b0000;
    blank[3] = LZ_BLANK && (disp[15:12] == 4'd0);
    blank[2] = LZ_BLANK && (disp[15:8] == 8'd0);
    blank[1] = LZ_BLANK && (disp[15:4] == 12'd0);
  end

  // Free-running scan; outputs follow the index one cycle later.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pre       <= '0;
      idx       <= '0;
      digit_sel <= 4'b1110;
      digit_bcd <= 4'd0;
    end else begin
      if (pre == PRE_MAX) begin
        pre <= '0;
        idx <= idx + 2'd1;
      end else begin
        pre <= pre + PW'(1);
      end
      digit_sel <= blank[idx] ? 4'b1111 : 4'(~(4'b0001 << idx));
      digit_bcd <= blank[idx] ? 4'd0 : disp[{idx, 2'b00} +: 4];
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl (CLK_DIV=4), with blanking and non-blanking builds.
module tb_seven_seg_scan_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        load = 1'b0;
  logic [13:0] value_in = '0;
  logic        busy, overflow, busy0, overflow0;
  logic [3:0]  digit_bcd, digit_sel, digit_bcd0, digit_sel0;
  int          total = 0;
  int          bad = 0;
  int          cyc;

  seven_seg_scan_ctrl #(.CLK_DIV(4), .LZ_BLANK(1'b1)) dut (
    .clock(clock), .reset_n(reset_n), .value_in(value_in), .load(load),
    .busy(busy), .overflow(overflow), .digit_bcd(digit_bcd), .digit_sel(digit_sel));

  seven_seg_scan_ctrl #(.CLK_DIV(4), .LZ_BLANK(1'b0)) dut0 (
    .clock(clock), .reset_n(reset_n), .value_in(value_in), .load(load),
    .busy(busy0), .overflow(overflow0), .digit_bcd(digit_bcd0), .digit_sel(digit_sel0));

  always #5 clock = ~clock;

  // Edges since reset release; the scanned digit follows from it directly.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  function automatic int out_idx(input int c);
    return (c == 0) ? 0 : ((c - 1) / 4) % 4;
  endfunction

  function automatic int pow10(input int k);
    int p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [3:0] exp_sel(input int k, input int v, input bit lz);
    logic [3:0] one = 4'b0001;
    if (lz && k >= 1 && v < pow10(k)) return 4'b1111;
    return ~(one << k);
  endfunction

  function automatic logic [3:0] exp_bcd(input int k, input int v, input bit lz);
    if (lz && k >= 1 && v < pow10(k)) return 4'd0;
    return 4'((v / pow10(k)) % 10);
  endfunction

  task automatic do_load(input int v);
    @(negedge clock);
    value_in = 14'(v);
    load = 1'b1;
    @(negedge clock);
    load = 1'b0;
  endtask

  task automatic test_reset;
    int k;
    #12;
    total++;
    if (busy !== 1'b0 || overflow !== 1'b0 || digit_sel !== 4'b1110 || digit_bcd !== 4'd0 ||
        digit_sel0 !== 4'b1110 || digit_bcd0 !== 4'd0) begin
      bad++;
      $display("FAIL reset_vals busy=%b ovf=%b sel=%b bcd=%0d sel0=%b bcd0=%0d expected 0 0 1110 0",
               busy, overflow, digit_sel, digit_bcd, digit_sel0, digit_bcd0);
    end
    @(negedge clock);
    reset_n = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clock);
      k = out_idx(cyc);
      total++;
      if (digit_sel !== exp_sel(k, 0, 1) || digit_bcd !== exp_bcd(k, 0, 1) ||
          digit_sel0 !== exp_sel(k, 0, 0) || digit_bcd0 !== exp_bcd(k, 0, 0)) begin
        bad++;
        $display("FAIL first_wrap cyc=%0d sel=%b sel0=%b bcd0=%0d expected sel=%b sel0=%b",
                 cyc, digit_sel, digit_sel0, digit_bcd0, exp_sel(k, 0, 1), exp_sel(k, 0, 0));
      end
    end
  endtask

  task automatic test_convert_1234;
    int k;
    do_load(1234);
    for (int i = 0; i < 14; i++) begin
      total++;
      if (busy !== 1'b1) begin
        bad++;
        $display("FAIL busy_high cycle=%0d busy=%b expected 1", i + 1, busy);
      end
      @(negedge clock);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL busy_low busy=%b expected 0", busy);
    end
    @(negedge clock);
    for (int n = 0; n < 16; n++) begin
      k = out_idx(cyc);
      total++;
      if (digit_sel !== exp_sel(k, 1234, 1) || digit_bcd !== exp_bcd(k, 1234, 1) ||
          digit_sel0 !== exp_sel(k, 1234, 0) || digit_bcd0 !== exp_bcd(k, 1234, 0)) begin
        bad++;
        $display("FAIL scan_1234 cyc=%0d sel=%b bcd=%0d expected sel=%b bcd=%0d",
                 cyc, digit_sel, digit_bcd, exp_sel(k, 1234, 1), exp_bcd(k, 1234, 1));
      end
      @(negedge clock);
    end
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL ovf_1234 overflow=%b expected 0", overflow);
    end
  endtask

  task automatic test_overflow;
    int k;
    int vals[2] = '{12000, 5};
    int shown[2] = '{9999, 5};
    for (int j = 0; j < 2; j++) begin
      do_load(vals[j]);
      repeat (15) @(negedge clock);
      total++;
      if (overflow !== (j == 0) || busy !== 1'b0) begin
        bad++;
        $display("FAIL ovf_flag value=%0d overflow=%b busy=%b expected %0d 0",
                 vals[j], overflow, busy, (j == 0));
      end
      for (int n = 0; n < 16; n++) begin
        k = out_idx(cyc);
        total++;
        if (digit_sel !== exp_sel(k, shown[j], 1) || digit_bcd !== exp_bcd(k, shown[j], 1) ||
            digit_sel0 !== exp_sel(k, shown[j], 0) || digit_bcd0 !== exp_bcd(k, shown[j], 0)) begin
          bad++;
          $display("FAIL scan_sat value=%0d cyc=%0d sel=%b bcd=%0d expected sel=%b bcd=%0d", vals[j],
                   cyc, digit_sel, digit_bcd, exp_sel(k, shown[j], 1), exp_bcd(k, shown[j], 1));
        end
        @(negedge clock);
      end
    end
  endtask

  task automatic test_busy_ignore;
    int k;
    do_load(42);
    repeat (4) @(negedge clock);
    value_in = 14'd7777;
    load = 1'b1;
    @(negedge clock);
    load = 1'b0;
    repeat (10) @(negedge clock);
    for (int n = 0; n < 16; n++) begin
      k = out_idx(cyc);
      total++;
      if (busy !== 1'b0 || digit_sel !== exp_sel(k, 42, 1) || digit_bcd !== exp_bcd(k, 42, 1) ||
          digit_sel0 !== exp_sel(k, 42, 0) || digit_bcd0 !== exp_bcd(k, 42, 0)) begin
        bad++;
        $display("FAIL ignore_load cyc=%0d busy=%b sel=%b bcd=%0d sel0=%b bcd0=%0d expected 0 %b %0d %b %0d",
                 cyc, busy, digit_sel, digit_bcd, digit_sel0, digit_bcd0,
                 exp_sel(k, 42, 1), exp_bcd(k, 42, 1), exp_sel(k, 42, 0), exp_bcd(k, 42, 0));
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset_mid;
    int k;
    do_load(9999);
    repeat (6) @(negedge clock);
    reset_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || overflow !== 1'b0 || digit_sel !== 4'b1110 || digit_bcd !== 4'd0 ||
        digit_sel0 !== 4'b1110 || digit_bcd0 !== 4'd0) begin
      bad++;
      $display("FAIL reset_mid busy=%b ovf=%b sel=%b bcd=%0d sel0=%b bcd0=%0d expected 0 0 1110 0",
               busy, overflow, digit_sel, digit_bcd, digit_sel0, digit_bcd0);
    end
    @(negedge clock);
    reset_n = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      k = out_idx(cyc);
      total++;
      if (busy !== 1'b0 || digit_sel !== exp_sel(k, 0, 1) || digit_bcd !== exp_bcd(k, 0, 1) ||
          digit_sel0 !== exp_sel(k, 0, 0) || digit_bcd0 !== exp_bcd(k, 0, 0)) begin
        bad++;
        $display("FAIL after_reset cyc=%0d busy=%b sel=%b bcd=%0d expected 0 %b %0d",
                 cyc, busy, digit_sel, digit_bcd, exp_sel(k, 0, 1), exp_bcd(k, 0, 1));
      end
    end
  endtask

  task automatic test_back_to_back;
    int k;
    int shown;
    logic exp_busy;
    do_load(100);
    for (int t = 1; t <= 40; t++) begin
      k = out_idx(cyc);
      shown = (t < 16) ? 0 : ((t < 31) ? 100 : 200);
      exp_busy = ((t >= 1 && t <= 14) || (t >= 16 && t <= 29));
      total++;
      if (busy !== exp_busy || digit_sel !== exp_sel(k, shown, 1) || digit_bcd !== exp_bcd(k, shown, 1) ||
          digit_sel0 !== exp_sel(k, shown, 0) || digit_bcd0 !== exp_bcd(k, shown, 0)) begin
        bad++;
        $display("FAIL b2b t=%0d busy=%b sel=%b bcd=%0d sel0=%b bcd0=%0d expected %b %b %0d %b %0d",
                 t, busy, digit_sel, digit_bcd, digit_sel0, digit_bcd0, exp_busy,
                 exp_sel(k, shown, 1), exp_bcd(k, shown, 1), exp_sel(k, shown, 0), exp_bcd(k, shown, 0));
      end
      if (t == 15) begin
        value_in = 14'd200;
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clock);
    end
  endtask

  initial begin
    test_reset();
    test_convert_1234();
    test_overflow();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
